// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
//  Module   : memory_controller
//  Purpose  : Single-port 16-bit word memory behind a request/response
//             handshake. A request is captured in IDLE, waits LATENCY cycles,
//             performs one read or write, holds mem_response for RESP_CYCLES
//             cycles, then parks in RELEASE until the requester drops
//             mem_block. An idle-time preload port fills the array.
//  Ports    : clk, rst           - clock, async active-high reset
//             mem_block          - request pending
//             mem_mode           - 0 read, 1 write (sampled at capture)
//             mem_locator        - word address (sampled at capture)
//             mem_write          - write data (sampled at capture)
//             load_en/addr/data  - preload strobe, address, data
//             mem_read           - read data or write echo
//             mem_response       - completion strobe
//             load_ready         - preload accepted this cycle
//             addr_err           - sticky out-of-range flag
//  Revision : 1.0 - initial release
// ============================================================================
module memory_controller #(
   parameter int DEPTH       = 65536,
   parameter int LATENCY     = 2,
   parameter int RESP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_block,
   input  logic        mem_mode,
   input  logic [15:0] mem_locator,
   input  logic [15:0] mem_write,
   input  logic        load_en,
   input  logic [15:0] load_addr,
   input  logic [15:0] load_data,
   output logic [15:0] mem_read,
   output logic        mem_response,
   output logic        load_ready,
   output logic        addr_err
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // 17 bits so that DEPTH=65536 is representable in the range compare.
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);
   localparam logic [3:0]  LAT_W   = 4'(LATENCY);
   localparam logic [3:0]  RESP_W  = 4'(RESP_CYCLES - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   logic [1:0]    state;
   logic [3:0]    wait_cnt;
   logic [3:0]    resp_cnt;
   logic          cap_mode;
   logic [15:0]   cap_addr;
   logic [15:0]   cap_data;

   logic [15:0]   mem_array [DEPTH];

   logic          access_now;
   logic          cap_in_range;
   logic          load_in_range;
   logic          load_fire;
   logic          arr_we;
   logic [AW-1:0] arr_waddr;
   logic [15:0]   arr_wdata;

   assign load_ready    = (state == ST_IDLE) && !mem_block;
   assign access_now    = (state == ST_WAIT) && (wait_cnt == 4'd0);
   assign cap_in_range  = ({1'b0, cap_addr}  < DEPTH_W);
   assign load_in_range = ({1'b0, load_addr} < DEPTH_W);
   assign load_fire     = load_en && load_ready;

   // Single write port: an access write and a preload can never coincide
   // because preload requires IDLE and an access happens only in WAIT.
   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = '0;
      arr_wdata = '0;
      if (access_now && cap_mode && cap_in_range) begin
         arr_we    = 1'b1;
         arr_waddr = cap_addr[AW-1:0];
         arr_wdata = cap_data;
      end else if (load_fire && load_in_range) begin
         arr_we    = 1'b1;
         arr_waddr = load_addr[AW-1:0];
         arr_wdata = load_data;
      end
      // Nothing lands in the array while reset is held.
      if (rst) begin
         arr_we = 1'b0;
      end
   end

   // Array has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (arr_we) begin
         mem_array[arr_waddr] <= arr_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= 4'd0;
         resp_cnt     <= 4'd0;
         cap_mode     <= 1'b0;
         cap_addr     <= 16'h0000;
         cap_data     <= 16'h0000;
         mem_read     <= 16'h0000;
         mem_response <= 1'b0;
         addr_err     <= 1'b0;
      end else begin
         if (load_fire && !load_in_range) begin
            addr_err <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (mem_block) begin
                  cap_mode <= mem_mode;
                  cap_addr <= mem_locator;
                  cap_data <= mem_write;
                  wait_cnt <= LAT_W;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  if (!cap_in_range) begin
                     addr_err <= 1'b1;
                  end
                  if (cap_mode) begin
                     mem_read <= cap_data;
                  end else if (cap_in_range) begin
                     mem_read <= mem_array[cap_addr[AW-1:0]];
                  end else begin
                     mem_read <= 16'h0000;
                  end
                  mem_response <= 1'b1;
                  resp_cnt     <= RESP_W;
                  state        <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               // The access edge counts as the first response cycle.
               if (resp_cnt == 4'd0) begin
                  mem_response <= 1'b0;
                  state        <= ST_RELEASE;
               end else begin
                  resp_cnt <= resp_cnt - 4'd1;
               end
            end
            ST_RELEASE: begin
               if (!mem_block) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_controller
//  Purpose  : Directed, table-driven bench. Instance 0 uses DEPTH=256,
//             LATENCY=2, RESP_CYCLES=1; instance 1 uses the default DEPTH,
//             LATENCY=0, RESP_CYCLES=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        blk  [2];
   logic        mode [2];
   logic [15:0] loc  [2];
   logic [15:0] wd   [2];
   logic        len  [2];
   logic [15:0] ladr [2];
   logic [15:0] ldat [2];
   logic [15:0] rd   [2];
   logic        resp [2];
   logic        lrdy [2];
   logic        aerr [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_controller #(.DEPTH(256), .LATENCY(2), .RESP_CYCLES(1)) u_a (
      .clk(clk), .rst(rst),
      .mem_block(blk[0]), .mem_mode(mode[0]), .mem_locator(loc[0]), .mem_write(wd[0]),
      .load_en(len[0]), .load_addr(ladr[0]), .load_data(ldat[0]),
      .mem_read(rd[0]), .mem_response(resp[0]), .load_ready(lrdy[0]), .addr_err(aerr[0])
   );

   memory_controller #(.LATENCY(0), .RESP_CYCLES(3)) u_b (
      .clk(clk), .rst(rst),
      .mem_block(blk[1]), .mem_mode(mode[1]), .mem_locator(loc[1]), .mem_write(wd[1]),
      .load_en(len[1]), .load_addr(ladr[1]), .load_data(ldat[1]),
      .mem_read(rd[1]), .mem_response(resp[1]), .load_ready(lrdy[1]), .addr_err(aerr[1])
   );

   typedef struct {
      logic        mode;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        chk_read;
      logic [15:0] exp_read;
      logic        exp_err;
      int          hold;
   } vec_t;

   vec_t tv [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input int k, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      len[k] = 1'b1; ladr[k] = a; ldat[k] = d;
      @(negedge clk);
      len[k] = 1'b0;
   endtask

   task automatic drive(input int k, input logic m, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      mode[k] = m; loc[k] = a; wd[k] = d; blk[k] = 1'b1;
   endtask

   // Waits for the capture edge t0, then measures the response window.
   // Request fields are scrambled right after capture; they must not matter.
   task automatic observe(input int k, input string name, input int exp_first, input int exp_cnt,
                          input logic chk_read, input logic [15:0] exp_read,
                          input logic exp_err, input int hold);
      int first, cnt, extra;
      logic [15:0] held;
      first = 0; cnt = 0; extra = 0;
      @(posedge clk);
      #2;
      mode[k] = ~mode[k]; loc[k] = loc[k] ^ 16'h5A5A; wd[k] = ~wd[k]; len[k] = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (resp[k]) begin
            if (first == 0) first = n;
            cnt++;
         end else if (first != 0) begin
            break;
         end
      end
      check({name, " first_resp_edge"}, first, exp_first);
      check({name, " resp_cycles"}, cnt, exp_cnt);
      if (chk_read) check({name, " mem_read"}, rd[k], exp_read);
      check({name, " addr_err"}, aerr[k], exp_err);
      held = rd[k];
      for (int n = 0; n < hold; n++) begin
         @(posedge clk);
         #1;
         if (resp[k] || rd[k] !== held || lrdy[k]) extra++;
      end
      if (hold > 0) check({name, " held_release"}, extra, 0);
      @(negedge clk);
      blk[k] = 1'b0;
      @(posedge clk);
      #1;
      check({name, " load_ready_after"}, lrdy[k], 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      //        mode  addr      wdata    chk  exp_read  err  hold
      tv[0]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b0, 0};
      tv[1]  = '{1'b1, 16'h0020, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 0};
      tv[2]  = '{1'b0, 16'h0020, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 20};
      tv[3]  = '{1'b1, 16'h00FF, 16'h7777, 1'b1, 16'h7777, 1'b0, 0};
      tv[4]  = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h7777, 1'b0, 0};
      tv[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 0};
      tv[6]  = '{1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
      tv[7]  = '{1'b1, 16'h0100, 16'h9999, 1'b0, 16'h0000, 1'b1, 0};
      tv[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 0};
      tv[9]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
      tv[10] = '{1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0001, 1'b1, 0};
      tv[11] = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b1, 0};

      for (int k = 0; k < 2; k++) begin
         blk[k] = 1'b0; mode[k] = 1'b0; loc[k] = 16'h0; wd[k] = 16'h0;
         len[k] = 1'b0; ladr[k] = 16'h0; ldat[k] = 16'h0;
      end

      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset%0d mem_read", k), rd[k], 16'h0000);
         check($sformatf("reset%0d mem_response", k), resp[k], 1'b0);
         check($sformatf("reset%0d addr_err", k), aerr[k], 1'b0);
         check($sformatf("reset%0d load_ready", k), lrdy[k], 1'b1);
      end
      @(negedge clk);
      rst = 1'b0;

      preload(0, 16'h0010, 16'h1234);
      preload(0, 16'h0030, 16'h0001);
      preload(0, 16'h0000, 16'hA5A5);

      for (int i = 0; i < 12; i++) begin
         drive(0, tv[i].mode, tv[i].addr, tv[i].wdata);
         observe(0, $sformatf("vec%0d", i), 3, 1, tv[i].chk_read, tv[i].exp_read,
                 tv[i].exp_err, tv[i].hold);
      end

      // Reset in WAIT of a write: outputs clear at once, write is dropped.
      drive(0, 1'b1, 16'h0030, 16'h5555);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_wait mem_response", resp[0], 1'b0);
      check("rst_wait mem_read", rd[0], 16'h0000);
      check("rst_wait addr_err", aerr[0], 1'b0);
      // mem_block stays high through reset: new read request at first edge.
      mode[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      observe(0, "post_rst_read", 3, 1, 1'b1, 16'h0001, 1'b0, 0);

      // Instance 1: request and preload in the same cycle; request wins.
      preload(1, 16'h0050, 16'h1111);
      @(negedge clk);
      blk[1] = 1'b1; mode[1] = 1'b0; loc[1] = 16'h0050; wd[1] = 16'h0;
      len[1] = 1'b1; ladr[1] = 16'h0050; ldat[1] = 16'h2222;
      #1;
      check("collide load_ready", lrdy[1], 1'b0);
      observe(1, "collide_read", 1, 3, 1'b1, 16'h1111, 1'b0, 0);
      drive(1, 1'b0, 16'h0050, 16'h0000);
      observe(1, "collide_reread", 1, 3, 1'b1, 16'h1111, 1'b0, 0);
      drive(1, 1'b1, 16'hFFFF, 16'hCAFE);
      observe(1, "b_write_top", 1, 3, 1'b1, 16'hCAFE, 1'b0, 0);
      drive(1, 1'b0, 16'hFFFF, 16'h0000);
      observe(1, "b_read_top", 1, 3, 1'b1, 16'hCAFE, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Parameters
REQ-001 DEPTH, default 65536: number of 16-bit words in the backing array; power of two, 2..65536.
REQ-002 LATENCY, default 2: wait cycles inserted between request capture and access; range 0..15.
REQ-003 RESP_CYCLES, default 1: cycles mem_response is held high per transaction; range 1..15.

Interface
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 mem_block  in  1  request from command processor; high means access pending.
REQ-007 mem_mode  in  1  0 read, 1 write; sampled at capture only.
REQ-008 mem_locator  in  16  word address; sampled at capture only.
REQ-009 mem_write  in  16  write data; sampled at capture only.
REQ-010 load_en  in  1  preload strobe, used by bench/boot loader.
REQ-011 load_addr  in  16  preload address.
REQ-012 load_data  in  16  preload data.
REQ-013 mem_read  out  16  read data or write echo.
REQ-014 mem_response  out  1  completion; falling edge releases requester.
REQ-015 load_ready  out  1  combinational: state==IDLE and mem_block==0.
REQ-016 addr_err  out  1  sticky out-of-range flag.

Function
REQ-017 Four states: IDLE, WAIT, RESP, RELEASE.
REQ-018 IDLE: at posedge with mem_block==1, capture mem_mode/mem_locator/mem_write, load wait counter with LATENCY, go WAIT.
REQ-019 WAIT: counter decrements each posedge. The access executes at the posedge where counter==0; at that edge go RESP and set mem_response=1.
REQ-020 Access timing: capture at edge t0 means the access happens at edge t0+LATENCY+1. LATENCY=0 means the access happens at t0+1.
REQ-021 Read access: mem_read <= array[addr].
REQ-022 Write access: array[addr] <= captured data, and mem_read <= captured data (echo).
REQ-023 RESP: mem_response holds 1 for exactly RESP_CYCLES posedges, then goes 0 at the same edge the state goes to RELEASE.
REQ-024 RELEASE: stay until mem_block is sampled 0, then go IDLE. A held-high mem_block never triggers a second transaction.
REQ-025 mem_read holds its value until the next access or reset; it is stable throughout RESP and RELEASE.
REQ-026 Out of range (addr >= DEPTH): read returns 16'h0000, write is discarded, addr_err sets to 1; timing is unchanged.
REQ-027 No address wrap; the array index uses the full 16-bit compare against DEPTH.
REQ-028 mem_mode/mem_locator/mem_write changes after capture have no effect on the transaction.
REQ-029 Preload: at a posedge with load_en==1 and load_ready==1, array[load_addr] <= load_data. Out-of-range preload is discarded and sets addr_err.
REQ-030 A posedge with load_en==1 and load_ready==0 drops the load silently.
REQ-031 If mem_block rises in the same cycle as load_en, load_ready is 0, so the request wins and the load is dropped.
REQ-032 Exactly one array write per posedge at most.
REQ-033 Array contents are uninitialised except for writes performed by this block.

Reset
REQ-034 rst high: state=IDLE, counters=0, mem_read=16'h0000, mem_response=0, addr_err=0, immediately and regardless of clk.
REQ-035 Reset mid-transaction aborts it; a write not yet at its access edge is not performed. Array contents are preserved.
REQ-036 After rst falls, a mem_block still high is treated as a new request at the first posedge.

Verification
REQ-037 Preload 16'h1234 at 16'h0010; read 16'h0010 with LATENCY=2, RESP_CYCLES=1 -> mem_response high exactly at edge t0+3 for one cycle, mem_read=16'h1234.
REQ-038 Write 16'hBEEF to 16'h0020, release, read 16'h0020 -> first response echoes 16'hBEEF, second read returns 16'hBEEF.
REQ-039 Hold mem_block high for 20 cycles after a response -> exactly one mem_response pulse, state stays RELEASE until mem_block drops.
REQ-040 DEPTH=256, read 16'h0100 -> mem_read=16'h0000, addr_err=1. A subsequent write to 16'h0100 does not alter array[16'h0000].
REQ-041 Assert rst during WAIT of a write of 16'h5555 to 16'h0030 (preloaded 16'h0001) -> mem_response=0 immediately, a later read returns 16'h0001.
REQ-042 load_en and a mem_block rise in the same cycle -> the request is served and the load target keeps its old value; LATENCY=0, RESP_CYCLES=3 gives response high for edges t0+1..t0+3.
